i2s_rx_core: RTL and testbench
==============================

// Module: i2s_rx_core
// PURPOSE
//  I2S receiver (deserializer). Mirror of the i2s_tx path in i2s_trx; fills the i2s_rx slot there.
//  Samples codec sdata against the lrck/sclk produced by i2s_clk, all in the mclk domain.
//  Emits one left/right parallel sample pair per frame with a single-cycle valid strobe.
//  Philips I2S format: MSB one sclk after lrck edge; lrck low = left.
// PARAMETERS
//  PDATA_WIDTH  32  width of each parallel channel word (pldata_out/prdata_out)
// PORTS
//  mclk_in     in   1            master clock; sole clock of the block
//  rst_in      in   1            synchronous, active-high reset
//  lrck_in     in   1            word select from i2s_clk (mclk-synchronous); 0=left, 1=right
//  sclk_in     in   1            bit clock from i2s_clk (mclk-synchronous, period >= 4 mclk)
//  sdata_in    in   1            serial data from codec, MSB first
//  pldata_out  out  PDATA_WIDTH  last complete left word
//  prdata_out  out  PDATA_WIDTH  last complete right word
//  pvalid_out  out  1            1-mclk pulse: pldata_out/prdata_out just updated as a pair
//  locked_out  out  1            high once first lrck edge seen after reset
// BEHAVIOUR
//  - Clock and reset: everything on posedge mclk_in. rst_in=1 forces:
//    all outputs 0, input regs 0, shift reg 0, bit counter 0, state SYNC, have_left 0.
//    A reset mid-frame discards partial words; the block resyncs as after power-up.
//  - Input stage: lrck_in, sclk_in, sdata_in each registered once (same stage, alignment kept).
//    sclk_q2 holds the previous sclk_q.
//  - Sample point: rise = sclk_q & ~sclk_q2. Only on rise cycles are lrck_q and sdata_q sampled.
//    lrck_s holds lrck_q from the previous rise. chg = rise & (lrck_q != lrck_s).
//  - Bit capture (states LEFT/RIGHT, on rise):
//    if bit_cnt < PDATA_WIDTH: shift[PDATA_WIDTH-1-bit_cnt] <= sdata_q.
//    bit_cnt saturates at PDATA_WIDTH; extra bits are ignored (truncate LSBs beyond width).
//    Fewer bits than PDATA_WIDTH: word is left-justified and unfilled LSBs stay 0.
//  - Word boundary: the bit sampled on a chg rise is the LSB of the OUTGOING channel (1-bit I2S delay).
//    It is captured first, then the word is committed.
//    Then shift is cleared and bit_cnt set to 0, so the next rise is the new channel's MSB.
//  - FSM:
//    SYNC : ignore data. On chg -> LEFT if lrck_q=0 else RIGHT; locked_out<=1; have_left<=0.
//    LEFT : on chg -> left_hold<=word; have_left<=1; -> RIGHT.
//    RIGHT: on chg -> if have_left: pldata_out<=left_hold, prdata_out<=word, pvalid_out<=1 next cycle;
//           have_left<=0; -> LEFT.
//           If have_left=0, the right word is discarded (partial first frame).
//  - Latency: pvalid_out is asserted on the mclk edge following the register update of chg.
//    That is the cycle after the right-word commit. Outputs are stable until the next pvalid_out.
//  - pvalid_out is high for exactly one mclk. Never asserted in SYNC or for the first partial frame.
//  - lrck_q change without rise: no effect (lrck is only evaluated at sample points).
//  - locked_out stays 1 until rst_in.
// STRUCTURE
//  - Shared header i2s_defs.vh (also used by i2s_tx/i2s_clk):
//    LRCK_LEFT=1'b0 / LRCK_RIGHT=1'b1.
//    Rx FSM encodings ST_SYNC/ST_LEFT/ST_RIGHT.
//    Bit-counter width macro $clog2(PDATA_WIDTH+1).
//  - One sub-module: i2s_edge_det, which holds the sclk input reg, the rise pulse, and the lrck_s change detect.
//    Its input registers are reusable by i2s_tx.
//  - FSM, shift register, hold/output registers live in i2s_rx_core.
//  - i2s_trx instantiates i2s_rx_core in place of the empty i2s_rx.
//    Add a sdata_in top port plus pldata_out/prdata_out/pvalid_out.
// TESTING (bench drives sclk/lrck via i2s_clk defaults: 64 sclk/frame, 32 bits/channel)
//  1. Reset: hold rst_in 5 mclk -> all outputs 0, locked_out=0. Assert rst_in mid-word -> same, then resync.
//  2. Start mid-right-channel; send L=32'hA5A5_0001, R=32'h8000_00FF.
//     -> no pvalid for the partial frame. Exactly one pvalid pulse with exactly that pair, 1 mclk after the
//     L->R... i.e. right-word commit.
//  3. Back-to-back frames (L,R)=(32'h0000_0001,32'hFFFF_FFFE),(32'h7FFF_FFFF,32'h8000_0000).
//     -> two pulses, 256 mclk apart, correct values, no bit slip.
//  4. PDATA_WIDTH=32 with 24 sclk/channel (48 sclk/frame), L=24'h123456, R=24'hABCDEF.
//     -> pldata_out=32'h1234_5600, prdata_out=32'hABCD_EF00.
//  5. PDATA_WIDTH=16 at 32 sclk/channel, L=32'hCAFE_BEEF.
//     -> pldata_out=16'hCAFE (truncation, no overflow into R).
//  6. Loopback: i2s_trx sdata_out->sdata_in, random pldata_in/prdata_in held for >= 2 frames.
//     -> received pair equals transmitted pair on every pvalid_out. Scoreboard: 1000 frames, 0 mismatches.

Source files
------------

// File: rtl/i2s_rx_core_pkg.sv
// ============================================================================
// Module   : i2s_rx_core_pkg
// Purpose  : Shared I2S receive definitions: lrck polarity, rx FSM states,
//            bit-counter width helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2s_rx_core_pkg;

  localparam logic LRCK_LEFT  = 1'b0;
  localparam logic LRCK_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } rx_state_e;

  // Counter must be able to hold the saturation value PDATA_WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_edge_det.sv
// ============================================================================
// Module   : i2s_edge_det
// Purpose  : Registers lrck/sclk/sdata in one stage, detects sclk rise and
//            an lrck change between consecutive sclk rises.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_lrck,
  input  logic i_sclk,
  input  logic i_sdata,
  output logic o_lrck_q,
  output logic o_sdata_q,
  output logic o_rise,
  output logic o_chg
);

  logic r_lrck_q;
  logic r_sclk_q;
  logic r_sclk_q2;
  logic r_sdata_q;
  logic r_lrck_s;
  logic w_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lrck_q  <= 1'b0;
      r_sclk_q  <= 1'b0;
      r_sclk_q2 <= 1'b0;
      r_sdata_q <= 1'b0;
      r_lrck_s  <= 1'b0;
    end else begin
      r_lrck_q  <= i_lrck;
      r_sclk_q  <= i_sclk;
      r_sdata_q <= i_sdata;
      r_sclk_q2 <= r_sclk_q;
      // lrck is only meaningful at sample points; glitches between rises are ignored
      if (w_rise) begin
        r_lrck_s <= r_lrck_q;
      end
    end
  end

  assign w_rise    = r_sclk_q & ~r_sclk_q2;
  assign o_rise    = w_rise;
  assign o_chg     = w_rise & (r_lrck_q != r_lrck_s);
  assign o_lrck_q  = r_lrck_q;
  assign o_sdata_q = r_sdata_q;

endmodule

`default_nettype wire

// File: rtl/i2s_rx_core.sv
// ============================================================================
// Module   : i2s_rx_core
// Purpose  : Philips I2S receiver; deserialises sdata into a left/right word
//            pair with a one-mclk valid strobe per complete frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_rx_core
  import i2s_rx_core_pkg::*;
#(
  parameter int PDATA_WIDTH = 32
) (
  input  logic                   mclk_in,
  input  logic                   rst_in,
  input  logic                   lrck_in,
  input  logic                   sclk_in,
  input  logic                   sdata_in,
  output logic [PDATA_WIDTH-1:0] pldata_out,
  output logic [PDATA_WIDTH-1:0] prdata_out,
  output logic                   pvalid_out,
  output logic                   locked_out
);

  localparam int                   CW     = cnt_width(PDATA_WIDTH);
  localparam logic [CW-1:0]        c_full = CW'(PDATA_WIDTH);
  localparam logic [PDATA_WIDTH-1:0] c_msb = {1'b1, {(PDATA_WIDTH-1){1'b0}}};

  logic                   w_lrck_q;
  logic                   w_sdata_q;
  logic                   w_rise;
  logic                   w_chg;
  logic [PDATA_WIDTH-1:0] w_mask;
  logic [PDATA_WIDTH-1:0] w_word;

  rx_state_e              r_state;
  logic [PDATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]          r_bit_cnt;
  logic [PDATA_WIDTH-1:0] r_left_hold;
  logic                   r_have_left;
  logic                   r_pend;

  i2s_edge_det u_edge_det (
    .clk       (mclk_in),
    .rst       (rst_in),
    .i_lrck    (lrck_in),
    .i_sclk    (sclk_in),
    .i_sdata   (sdata_in),
    .o_lrck_q  (w_lrck_q),
    .o_sdata_q (w_sdata_q),
    .o_rise    (w_rise),
    .o_chg     (w_chg)
  );

  // Shifting the MSB mask out past the LSB naturally drops bits beyond the width.
  assign w_mask = c_msb >> r_bit_cnt;
  assign w_word = r_shift | ({PDATA_WIDTH{w_sdata_q}} & w_mask);

  always_ff @(posedge mclk_in) begin
    if (rst_in) begin
      r_state     <= ST_SYNC;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_left_hold <= '0;
      r_have_left <= 1'b0;
      r_pend      <= 1'b0;
      pldata_out  <= '0;
      prdata_out  <= '0;
      pvalid_out  <= 1'b0;
      locked_out  <= 1'b0;
    end else begin
      pvalid_out <= r_pend;
      r_pend     <= 1'b0;

      if (w_rise) begin
        if (w_chg) begin
          r_shift   <= '0;
          r_bit_cnt <= '0;
        end else if (r_state != ST_SYNC) begin
          r_shift <= w_word;
          if (r_bit_cnt != c_full) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
      end

      if (w_chg) begin
        case (r_state)
          ST_SYNC: begin
            r_state     <= (w_lrck_q == LRCK_RIGHT) ? ST_RIGHT : ST_LEFT;
            locked_out  <= 1'b1;
            r_have_left <= 1'b0;
          end
          ST_LEFT: begin
            r_left_hold <= w_word;
            r_have_left <= 1'b1;
            r_state     <= ST_RIGHT;
          end
          ST_RIGHT: begin
            // A right word with no preceding left word belongs to a partial frame.
            if (r_have_left) begin
              pldata_out <= r_left_hold;
              prdata_out <= w_word;
              r_pend     <= 1'b1;
            end
            r_have_left <= 1'b0;
            r_state     <= ST_LEFT;
          end
          default: begin
            r_state <= ST_SYNC;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2s_rx_core.sv
// ============================================================================
// Module   : tb_i2s_rx_core
// Purpose  : Directed bench for i2s_rx_core (32- and 16-bit instances on a
//            shared I2S stream).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2s_rx_core;

  logic        mclk_in  = 1'b0;
  logic        rst_in   = 1'b1;
  logic        lrck_in  = 1'b0;
  logic        sclk_in  = 1'b0;
  logic        sdata_in = 1'b0;
  logic [31:0] pl32, pr32;
  logic [15:0] pl16, pr16;
  logic        pv32, pv16, lk32, lk16;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int run32 = 0;
  int maxrun32 = 0;
  logic prev_lsb = 1'b0;

  logic [31:0] q_l32[$], q_r32[$], q_l16[$], q_r16[$];
  int          q_t32[$];
  logic [31:0] exp_l[$], exp_r[$];

  i2s_rx_core #(.PDATA_WIDTH(32)) dut32 (
    .mclk_in(mclk_in), .rst_in(rst_in), .lrck_in(lrck_in), .sclk_in(sclk_in),
    .sdata_in(sdata_in), .pldata_out(pl32), .prdata_out(pr32),
    .pvalid_out(pv32), .locked_out(lk32)
  );

  i2s_rx_core #(.PDATA_WIDTH(16)) dut16 (
    .mclk_in(mclk_in), .rst_in(rst_in), .lrck_in(lrck_in), .sclk_in(sclk_in),
    .sdata_in(sdata_in), .pldata_out(pl16), .prdata_out(pr16),
    .pvalid_out(pv16), .locked_out(lk16)
  );

  always #5 mclk_in = ~mclk_in;

  always @(posedge mclk_in) cyc++;

  always @(negedge mclk_in) begin
    if (pv32) begin
      q_l32.push_back(pl32);
      q_r32.push_back(pr32);
      q_t32.push_back(cyc);
      run32++;
      if (run32 > maxrun32) maxrun32 = run32;
    end else begin
      run32 = 0;
    end
    if (pv16) begin
      q_l16.push_back({16'h0, pl16});
      q_r16.push_back({16'h0, pr16});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic slot(input logic lr, input logic d);
    @(negedge mclk_in);
    lrck_in  = lr;
    sdata_in = d;
    sclk_in  = 1'b0;
    @(negedge mclk_in);
    @(negedge mclk_in);
    sclk_in = 1'b1;
    @(negedge mclk_in);
  endtask

  // Philips format: first slot of a channel carries the previous channel's LSB.
  task automatic send_channel(input logic lr, input logic [31:0] w, input int n);
    slot(lr, prev_lsb);
    for (int k = 1; k < n; k++) slot(lr, w[n-k]);
    prev_lsb = w[0];
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
    send_channel(1'b0, l, n);
    send_channel(1'b1, r, n);
  endtask

  task automatic partial_right();
    for (int k = 0; k < 7; k++) slot(1'b1, 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset(input int n);
    @(negedge mclk_in);
    rst_in   = 1'b1;
    sclk_in  = 1'b0;
    lrck_in  = 1'b0;
    sdata_in = 1'b0;
    prev_lsb = 1'b0;
    repeat (n) @(negedge mclk_in);
    q_l32.delete(); q_r32.delete(); q_t32.delete();
    q_l16.delete(); q_r16.delete();
  endtask

  task automatic release_reset();
    rst_in = 1'b0;
    repeat (3) @(negedge mclk_in);
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (q.size() > i) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  initial begin
    logic [31:0] l, r;

    // 1. reset state
    do_reset(5);
    check("rst_pl32", pl32, 32'h0);
    check("rst_pr32", pr32, 32'h0);
    check("rst_pv32", {31'b0, pv32}, 32'h0);
    check("rst_lk32", {31'b0, lk32}, 32'h0);
    check("rst_pl16", {16'h0, pl16}, 32'h0);
    release_reset();

    // 2. start mid-right, one full frame
    partial_right();
    check("lock_after_edge", {31'b0, lk32}, 32'h1);
    send_frame(32'hA5A5_0001, 32'h8000_00FF, 32);
    check("no_pv_partial", q_l32.size(), 32'd0);
    send_channel(1'b0, 32'h0, 32);
    repeat (8) @(negedge mclk_in);
    check("t2_count", q_l32.size(), 32'd1);
    check("t2_left", qget(q_l32, 0), 32'hA5A5_0001);
    check("t2_right", qget(q_r32, 0), 32'h8000_00FF);
    check("t2_width", maxrun32, 32'd1);

    // 1b. reset mid-word clears everything
    send_channel(1'b1, 32'h1234_5678, 20);
    @(negedge mclk_in);
    rst_in = 1'b1;
    repeat (3) @(negedge mclk_in);
    check("midrst_pl", pl32, 32'h0);
    check("midrst_pr", pr32, 32'h0);
    check("midrst_lk", {31'b0, lk32}, 32'h0);
    check("midrst_pv", {31'b0, pv32}, 32'h0);

    // 3. back-to-back frames after resync
    do_reset(2);
    release_reset();
    partial_right();
    send_frame(32'h0000_0001, 32'hFFFF_FFFE, 32);
    send_frame(32'h7FFF_FFFF, 32'h8000_0000, 32);
    send_channel(1'b0, 32'h0, 32);
    repeat (8) @(negedge mclk_in);
    check("t3_count", q_l32.size(), 32'd2);
    check("t3_l0", qget(q_l32, 0), 32'h0000_0001);
    check("t3_r0", qget(q_r32, 0), 32'hFFFF_FFFE);
    check("t3_l1", qget(q_l32, 1), 32'h7FFF_FFFF);
    check("t3_r1", qget(q_r32, 1), 32'h8000_0000);
    check("t3_spacing", (q_t32.size() > 1) ? 32'(q_t32[1] - q_t32[0]) : 32'hFFFF_FFFF, 32'd256);

    // 4. 24 bits per channel into a 32-bit word
    do_reset(2);
    release_reset();
    partial_right();
    send_frame(32'h0012_3456, 32'h00AB_CDEF, 24);
    send_channel(1'b0, 32'h0, 24);
    repeat (8) @(negedge mclk_in);
    check("t4_count", q_l32.size(), 32'd1);
    check("t4_left", qget(q_l32, 0), 32'h1234_5600);
    check("t4_right", qget(q_r32, 0), 32'hABCD_EF00);

    // 5. 32 bits per channel into a 16-bit word
    do_reset(2);
    release_reset();
    partial_right();
    send_frame(32'hCAFE_BEEF, 32'h1357_9BDF, 32);
    send_channel(1'b0, 32'h0, 32);
    repeat (8) @(negedge mclk_in);
    check("t5_count16", q_l16.size(), 32'd1);
    check("t5_left16", qget(q_l16, 0), 32'h0000_CAFE);
    check("t5_right16", qget(q_r16, 0), 32'h0000_1357);
    check("t5_left32", qget(q_l32, 0), 32'hCAFE_BEEF);
    check("t5_right32", qget(q_r32, 0), 32'h1357_9BDF);

    // 6. random frame stream against a scoreboard
    do_reset(2);
    release_reset();
    partial_right();
    exp_l.delete();
    exp_r.delete();
    for (int i = 0; i < 20; i++) begin
      l = $urandom;
      r = $urandom;
      exp_l.push_back(l);
      exp_r.push_back(r);
      send_frame(l, r, 32);
    end
    send_channel(1'b0, 32'h0, 32);
    repeat (8) @(negedge mclk_in);
    check("t6_count", q_l32.size(), 32'd20);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("t6_l%0d", i), qget(q_l32, i), exp_l[i]);
      check($sformatf("t6_r%0d", i), qget(q_r32, i), exp_r[i]);
    end
    check("t6_width", maxrun32, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
